// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared timing defaults, totals, horizontal state encoding and strobe bundle.
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int CNT_W = 10;
  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} h_state_e;
  typedef struct packed {
    logic hs_set;
    logic hs_rst;
    logic vs_set;
    logic vs_rst;
    logic de_set;
    logic de_rst;
    logic frame_start;
  } strobes_t;
endpackage

// File: rtl/axis_counter.sv
// axis_counter: wrapping 0..LAST counter with enable; exposes next value and terminal count.
module axis_counter
  import vga_timing_pkg::*;
#(
  parameter int W = CNT_W,
  parameter logic [W-1:0] LAST = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (en_i) cnt_q <= nxt_o;
  assign tc_o = cnt_q == LAST;
  assign nxt_o = tc_o ? '0 : cnt_q + W'(1);
  assign cnt_o = cnt_q;
endmodule

// File: rtl/sync_sr_driver.sv
// sync_sr_driver: VGA timing generator emitting one-cycle set/reset strobes for
// external hsync/vsync/display-enable SR flops, plus raster position counters.
module sync_sr_driver
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             hs_set,
  output logic             hs_rst,
  output logic             vs_set,
  output logic             vs_rst,
  output logic             de_set,
  output logic             de_rst,
  output logic             frame_start,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt
);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_FP_AT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_AT = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_BP_AT = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_AT = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_BP_AT = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  logic init_q;
  logic h_adv, v_adv, h_tc, v_tc;
  logic [CNT_W-1:0] h_nxt, v_nxt, v_n;
  h_state_e state_q, state_d;
  strobes_t str_q, str_d;
  // The cycle after reset is spent aligning the downstream flops; counters hold at (0,0).
  assign h_adv = en && !init_q;
  assign v_adv = h_adv && h_tc;
  assign v_n = h_tc ? v_nxt : v_cnt;
  axis_counter #(.W(CNT_W), .LAST(H_LAST)) u_h (
    .clk(clk), .rst(rst), .en_i(h_adv), .cnt_o(h_cnt), .nxt_o(h_nxt), .tc_o(h_tc)
  );
  axis_counter #(.W(CNT_W), .LAST(V_LAST)) u_v (
    .clk(clk), .rst(rst), .en_i(v_adv), .cnt_o(v_cnt), .nxt_o(v_nxt), .tc_o(v_tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      init_q <= 1'b1;
      state_q <= ACTIVE;
      str_q <= '0;
    end else begin
      init_q <= 1'b0;
      state_q <= state_d;
      str_q <= str_d;
    end
  always_comb begin
    state_d = state_q;
    if (h_adv)
      state_d = h_nxt < H_FP_AT ? ACTIVE : h_nxt < H_SYNC_AT ? FRONT : h_nxt < H_BP_AT ? SYNC : BACK;
  end
  // Strobes are decoded from the values the counters are about to take, so they line up with them.
  always_comb begin
    str_d = '0;
    if (init_q) begin
      str_d.hs_set = 1'b1;
      str_d.vs_set = 1'b1;
      str_d.de_set = 1'b1;
      str_d.frame_start = 1'b1;
    end else if (h_adv) begin
      str_d.hs_rst = state_d == SYNC && state_q != SYNC;
      str_d.hs_set = state_d == BACK && state_q != BACK;
      str_d.vs_rst = h_tc && v_n == V_SYNC_AT;
      str_d.vs_set = h_tc && v_n == V_BP_AT;
      str_d.de_set = h_tc && v_n < V_ACT;
      str_d.de_rst = h_nxt == H_FP_AT && v_n < V_ACT;
      str_d.frame_start = h_tc && v_tc;
    end
  end
  assign {hs_set, hs_rst, vs_set, vs_rst, de_set, de_rst, frame_start} = str_q;
endmodule

// File: tb/tb_sync_sr_driver.sv
// tb_sync_sr_driver: scoreboard bench on a reduced raster (16x9); expected strobe
// events are queued ahead of stimulus and a negedge monitor pops and compares them.
module tb_sync_sr_driver;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3, VA = 4, VF = 2, VS = 1, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic [6:0] HSS = 7'b1000000, HSR = 7'b0100000, VSS = 7'b0010000, VSR = 7'b0001000;
  localparam logic [6:0] DES = 7'b0000100, DER = 7'b0000010, FS = 7'b0000001;
  typedef struct {logic [6:0] s; int h; int v;} ev_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic hs_set, hs_rst, vs_set, vs_rst, de_set, de_rst, frame_start;
  logic [9:0] h_cnt, v_cnt;
  logic [6:0] sv;
  ev_t q[$];
  ev_t e_m;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sync_sr_driver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .hs_set(hs_set), .hs_rst(hs_rst), .vs_set(vs_set), .vs_rst(vs_rst),
    .de_set(de_set), .de_rst(de_rst), .frame_start(frame_start),
    .h_cnt(h_cnt), .v_cnt(v_cnt)
  );
  assign sv = {hs_set, hs_rst, vs_set, vs_rst, de_set, de_rst, frame_start};
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input logic [6:0] s, input int h, input int v);
    ev_t e;
    e.s = s;
    e.h = h;
    e.v = v;
    q.push_back(e);
  endtask
  // Queue every strobe event of one frame whose position (v*HT+h) is <= lim.
  task automatic push_frame(input int lim);
    logic [6:0] s0;
    push(HSS | VSS | DES | FS, 0, 0);
    for (int v = 0; v < VT; v++) begin
      s0 = (v < VA ? DES : 7'b0) | (v == VA + VF ? VSR : 7'b0) | (v == VA + VF + VS ? VSS : 7'b0);
      if (v > 0 && s0 != 7'b0 && v * HT <= lim) push(s0, 0, v);
      if (v < VA && v * HT + HA <= lim) push(DER, HA, v);
      if (v * HT + HA + HF <= lim) push(HSR, HA + HF, v);
      if (v * HT + HA + HF + HS <= lim) push(HSS, HA + HF + HS, v);
    end
    if (lim >= HT * VT) push(DES | FS, 0, 0);
  endtask
  task automatic drain(input bit tog, input string name);
    int n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      #1;
      if (tog) en = ~en;
      n++;
    end
    en = 1'b0;
    chk(name, q.size(), 0);
  endtask
  always @(negedge clk) begin
    chk("hs_pair", int'(hs_set & hs_rst), 0);
    chk("vs_pair", int'(vs_set & vs_rst), 0);
    chk("de_pair", int'(de_set & de_rst), 0);
    if (sv != 7'b0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got %b expected none at h=%0d v=%0d", sv, h_cnt, v_cnt);
      end else begin
        e_m = q.pop_front();
        chk("strobes", int'(sv), int'(e_m.s));
        chk("h_cnt", int'(h_cnt), e_m.h);
        chk("v_cnt", int'(v_cnt), e_m.v);
      end
    end
  end
  initial begin
    int n;
    en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_h", int'(h_cnt), 0);
    chk("rst_v", int'(v_cnt), 0);
    chk("rst_strobes", int'(sv), 0);
    push_frame(HT * VT);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("init_h", int'(h_cnt), 0);
    @(negedge clk);
    #1;
    chk("h_after_init", int'(h_cnt), 1);
    drain(1'b0, "frame_a_drain");
    rst = 1'b1;
    push_frame(5 * HT + 10);
    @(negedge clk);
    #1;
    rst = 1'b0;
    en = 1'b1;
    n = 0;
    while (!(h_cnt == 10'd10 && v_cnt == 10'd5) && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach_mid_frame", int'(h_cnt == 10'd10 && v_cnt == 10'd5), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_h", int'(h_cnt), 0);
    chk("async_rst_v", int'(v_cnt), 0);
    chk("async_rst_strobes", int'(sv), 0);
    chk("mid_frame_drain", q.size(), 0);
    push_frame(HT * VT);
    @(negedge clk);
    #1;
    rst = 1'b0;
    en = 1'b1;
    drain(1'b1, "frame_toggle_drain");
    repeat (5) @(negedge clk);
    #1;
    chk("final_queue", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
